hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port instr_i  input  32  instruction currently in the ID stage.
REQ-004 SHALL have port id_valid_i  input  1  instr_i is a real instruction; when low, ID is treated as a bubble.
REQ-005 SHALL have port branch_taken_i  input  1  BEQ in EX resolved taken this cycle.
REQ-006 SHALL have port halt_req_i  input  1  debug halt request, level-sensitive.
REQ-007 SHALL have port pc_write_o  output  1  PC register load enable.
REQ-008 SHALL have port if_id_write_o  output  1  IF/ID register load enable.
REQ-009 SHALL have port if_id_flush_o  output  1  clear IF/ID to a bubble.
REQ-010 SHALL have port id_ex_bubble_o  output  1  load a bubble (all controls 0) into ID/EX.
REQ-011 SHALL have port halt_ack_o  output  1  pipeline drained and frozen.
REQ-012 SHALL have port stall_cnt_o  output  16  load-use stall cycles, saturating.
REQ-013 SHALL have port flush_cnt_o  output  16  taken-branch flushes, saturating.

Function
REQ-014 SHALL decode the {instr_i[14:12], instr_i[6:0]} classes as follows: ADDI 000/0010011, SRAI 101/0010011, LW 010/0000011, SW 010/0100011, BEQ 000/1100011, and R-type = any funct3 with opcode 0110011.
REQ-015 SHALL treat rs1 = instr_i[19:15] as used by all six classes, and rs2 = instr_i[24:20] as used only by SW, BEQ and R-type; any other encoding uses no source register.
REQ-016 SHALL track the EX-stage instruction internally in ex_load_q (1 bit) and ex_rd_q (5 bits), updated every clock.
  - If id_ex_bubble_o = 1 or id_valid_i = 0: load 0/0.
  - Otherwise: load (ID is LW, instr_i[11:7]).
REQ-017 SHALL detect load-use when all hold: state RUN, id_valid_i = 1, ex_load_q = 1, ex_rd_q != 0, and ex_rd_q equals a used rs1 or used rs2.
REQ-018 SHALL implement FSM states RUN, DRAIN, HALTED, with a 2-bit drain counter.
REQ-019 SHALL, in RUN, apply this priority: branch_taken_i > load-use > halt_req_i > normal.
REQ-020 SHALL, in RUN with branch_taken_i, drive pc_write_o = 1, if_id_write_o = 1, if_id_flush_o = 1 and id_ex_bubble_o = 1, increment flush_cnt_o, and stay in RUN.
REQ-021 SHALL, in RUN with load-use and no branch, drive pc_write_o = 0, if_id_write_o = 0, if_id_flush_o = 0 and id_ex_bubble_o = 1, and increment stall_cnt_o.
  - Stall lasts exactly one cycle, because the bubble clears ex_load_q.
REQ-022 SHALL, in RUN with halt_req_i and no branch, drive stall outputs as in REQ-021 and go to DRAIN with cnt = 0.
  - stall_cnt_o also increments if load-use coincides.
REQ-023 SHALL, in RUN with none of the above, drive pc_write_o = 1, if_id_write_o = 1, if_id_flush_o = 0 and id_ex_bubble_o = 0.
REQ-024 SHALL, in DRAIN, drive pc_write_o = 0, if_id_write_o = 0 and id_ex_bubble_o = 1, and increment cnt.
  - cnt = 2 goes to HALTED.
  - branch_taken_i and halt_req_i are ignored in DRAIN.
REQ-025 SHALL, in HALTED, drive the same outputs as DRAIN plus halt_ack_o = 1, returning to RUN on the first edge where halt_req_i = 0.
REQ-026 SHALL drive halt_ack_o = 0 in all states other than HALTED.
REQ-027 SHALL saturate both counters at 16'hFFFF with no wrap.
REQ-028 SHALL never assert if_id_flush_o outside RUN.

Reset
REQ-029 SHALL, while rst_i = 0, set state RUN, cnt = 0, ex_load_q = 0, ex_rd_q = 0, stall_cnt_o = 0 and flush_cnt_o = 0, regardless of clk_i.
REQ-030 SHALL, while rst_i = 0, force outputs to pc_write_o = 1, if_id_write_o = 1, if_id_flush_o = 0, id_ex_bubble_o = 0 and halt_ack_o = 0, independent of other inputs.
REQ-031 SHALL resume normally on the first rising edge after rst_i rises, with the first instruction treated as having no producer in EX.

Verification
REQ-032 SHALL pass: LW x5,0(x1), then ADDI x6,x5,1 -> one cycle with pc_write_o = 0, id_ex_bubble_o = 1; stall_cnt_o 0->1; next cycle all enables = 1.
REQ-033 SHALL pass: LW x5, then SW x5,0(x2) (rs2 match) -> one stall; LW x0, then ADDI x1,x0,1 -> no stall; LW x5, then SRAI x7,x6,3 -> no stall.
REQ-034 SHALL pass: branch_taken_i = 1 in a cycle that also has load-use -> flush = 1, bubble = 1, pc_write_o = 1; flush_cnt_o +1, stall_cnt_o unchanged, no stall next cycle.
REQ-035 SHALL pass: halt_req_i high from cycle c0 in RUN -> c0-c3 enables 0 and bubble 1; halt_ack_o = 1 from c4; halt_req_i dropped in c5 -> RUN with enables 1 in c6.
REQ-036 SHALL pass: rst_i pulsed low during DRAIN -> outputs immediately at reset values and counters 0; after release, no halt_ack_o until a new halt sequence completes.
REQ-037 SHALL pass: 65536 back-to-back load-use stalls -> stall_cnt_o holds 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a debug halt
// sequence that drains the pipeline before freezing it.
module hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        id_valid_i,
  input  logic        branch_taken_i,
  input  logic        halt_req_i,
  output logic        pc_write_o,
  output logic        if_id_write_o,
  output logic        if_id_flush_o,
  output logic        id_ex_bubble_o,
  output logic        halt_ack_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpReg  = 7'b0110011;

  state_e      state_q;
  logic [1:0]  drain_cnt_q;
  logic        ex_load_q;
  logic [4:0]  ex_rd_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_addi, is_srai, is_lw, is_sw, is_beq, is_rtype;
  logic        uses_rs1, uses_rs2;
  logic        rs1_hit, rs2_hit;
  logic        load_use;
  logic        bubble;
  logic        unused_instr;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign rd     = instr_i[11:7];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign unused_instr = ^instr_i[31:25];

  assign is_addi  = (opcode == OpImm)    && (funct3 == 3'b000);
  assign is_srai  = (opcode == OpImm)    && (funct3 == 3'b101);
  assign is_lw    = (opcode == OpLoad)   && (funct3 == 3'b010);
  assign is_sw    = (opcode == OpStore)  && (funct3 == 3'b010);
  assign is_beq   = (opcode == OpBranch) && (funct3 == 3'b000);
  assign is_rtype = (opcode == OpReg);

  assign uses_rs1 = is_addi | is_srai | is_lw | is_sw | is_beq | is_rtype;
  assign uses_rs2 = is_sw | is_beq | is_rtype;

  assign rs1_hit = uses_rs1 && (rs1 == ex_rd_q);
  assign rs2_hit = uses_rs2 && (rs2 == ex_rd_q);

  // x0 is never a real producer, so a load into x0 cannot create a hazard.
  assign load_use = (state_q == StRun) && id_valid_i && ex_load_q && (ex_rd_q != 5'd0) &&
                    (rs1_hit || rs2_hit);

  // Outputs are Mealy: branch and load-use must act in the same cycle they are seen.
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    halt_ack_o     = 1'b0;
    if (rst_i) begin
      unique case (state_q)
        StRun: begin
          if (branch_taken_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_bubble_o = 1'b1;
          end else if (load_use || halt_req_i) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
          end
        end
        StDrain: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
        end
        StHalted: begin
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          halt_ack_o     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bubble = id_ex_bubble_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StRun;
      drain_cnt_q <= 2'd0;
      ex_load_q   <= 1'b0;
      ex_rd_q     <= 5'd0;
      stall_cnt_o <= 16'd0;
      flush_cnt_o <= 16'd0;
    end else begin
      if (bubble || !id_valid_i) begin
        ex_load_q <= 1'b0;
        ex_rd_q   <= 5'd0;
      end else begin
        ex_load_q <= is_lw;
        ex_rd_q   <= rd;
      end

      unique case (state_q)
        StRun: begin
          if (branch_taken_i) begin
            if (flush_cnt_o != 16'hFFFF) flush_cnt_o <= flush_cnt_o + 16'd1;
          end else begin
            if (load_use && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
            if (halt_req_i) begin
              state_q     <= StDrain;
              drain_cnt_q <= 2'd0;
            end
          end
        end
        StDrain: begin
          // Three drain cycles empty EX/MEM/WB before the freeze is acknowledged.
          if (drain_cnt_q == 2'd2) state_q <= StHalted;
          else                     drain_cnt_q <= drain_cnt_q + 2'd1;
        end
        StHalted: begin
          if (!halt_req_i) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
